// File: rtl/ctrl_frame_transceiver.sv
// Control-lane framer: sends CRC-16 protected payload frames MSB-first over a narrow lane and
// validates received frames by length and CRC residue.
module ctrl_frame_transceiver #(
    parameter int unsigned PAYLOAD_W = 128,
    parameter int unsigned LANE_W    = 2,
    parameter int unsigned IFG_CYC   = 2,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    input  logic                 tx_start,
    input  logic [PAYLOAD_W-1:0] tx_payload_i,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 ctrl_tx_clk,
    output logic                 ctrl_tx_en,
    output logic [LANE_W-1:0]    ctrl_tx_data,
    output logic                 ctrl_rx_clk,
    input  logic                 ctrl_rx_dv,
    input  logic [LANE_W-1:0]    ctrl_rx_data,
    output logic [PAYLOAD_W-1:0] rx_payload_o,
    output logic                 rx_valid,
    output logic                 rx_err,
    output logic                 rx_good,
    output logic [CNT_W-1:0]     rx_good_cnt,
    output logic [CNT_W-1:0]     rx_err_cnt,
    output logic [7:0]           rx_bit_cnt_o
);
    localparam int unsigned FRAME_W   = PAYLOAD_W + 16;
    localparam int unsigned BEATS     = FRAME_W / LANE_W;
    localparam int unsigned PAY_BEATS = PAYLOAD_W / LANE_W;
    localparam int unsigned BEAT_W    = $clog2(BEATS + 1);
    localparam int unsigned GAP_W     = $clog2(IFG_CYC + 2);

    // CRC-16/CCITT-FALSE advanced by one lane beat, MSB of the beat first
    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [LANE_W-1:0] d);
        logic [15:0] c;
        c = crc;
        for (int i = LANE_W - 1; i >= 0; i--) begin
            if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    typedef enum logic [1:0] {StIdle, StSend, StGap} tx_state_e;

    tx_state_e              state_q, state_d;
    logic [BEAT_W-1:0]      beat_q;
    logic [GAP_W-1:0]       gap_q;
    logic [PAYLOAD_W-1:0]   tx_sh_q;
    logic [15:0]            tx_crc_q;
    logic                   tx_done_q;
    logic                   last_beat, in_payload, tx_accept;

    assign ctrl_tx_clk = sys_clk;
    assign ctrl_rx_clk = sys_clk;
    assign last_beat   = (beat_q == BEAT_W'(BEATS - 1));
    assign in_payload  = (beat_q < BEAT_W'(PAY_BEATS));
    assign tx_accept   = (state_q == StIdle) && tx_start;
    assign tx_done     = tx_done_q;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (tx_start) state_d = StSend;
            StSend: if (last_beat) state_d = (IFG_CYC == 0) ? StIdle : StGap;
            StGap:  if (gap_q == GAP_W'(IFG_CYC - 1)) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ctrl_tx_en   = (state_q == StSend);
        tx_busy      = (state_q != StIdle);
        ctrl_tx_data = '0;
        if (state_q == StSend) begin
            ctrl_tx_data = in_payload ? tx_sh_q[PAYLOAD_W-1 -: LANE_W] : tx_crc_q[15 -: LANE_W];
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q    <= '0;
            gap_q     <= '0;
            tx_sh_q   <= '0;
            tx_crc_q  <= '0;
            tx_done_q <= 1'b0;
        end else begin
            tx_done_q <= (state_q == StSend) && last_beat;
            unique case (state_q)
                StIdle: begin
                    if (tx_start) begin
                        tx_sh_q  <= tx_payload_i;
                        tx_crc_q <= 16'hFFFF;
                        beat_q   <= '0;
                    end
                end
                StSend: begin
                    beat_q <= beat_q + BEAT_W'(1);
                    gap_q  <= '0;
                    if (in_payload) begin
                        tx_sh_q  <= tx_sh_q << LANE_W;
                        tx_crc_q <= crc_step(tx_crc_q, tx_sh_q[PAYLOAD_W-1 -: LANE_W]);
                    end else begin
                        tx_crc_q <= tx_crc_q << LANE_W;
                    end
                end
                StGap: gap_q <= gap_q + GAP_W'(1);
                default: ;
            endcase
        end
    end

    logic                   rx_dv_q;
    logic [FRAME_W-1:0]     rx_sh_q;
    logic [15:0]            rx_crc_q;
    logic [7:0]             rx_bits_q;
    logic                   overlong_q;
    logic                   rx_valid_q, rx_err_q, rx_good_q;
    logic [PAYLOAD_W-1:0]   rx_payload_q;
    logic [CNT_W-1:0]       good_cnt_q, err_cnt_q;
    logic                   rx_rise, rx_eof, frame_good, over_next;
    logic [15:0]            crc_seed;
    logic [8:0]             bits_sum;
    logic [7:0]             bits_next;

    always_comb begin
        rx_rise    = ctrl_rx_dv && !rx_dv_q;
        crc_seed   = rx_rise ? 16'hFFFF : rx_crc_q;
        bits_sum   = (rx_rise ? 9'd0 : {1'b0, rx_bits_q}) + 9'(LANE_W);
        bits_next  = bits_sum[8] ? 8'hFF : bits_sum[7:0];
        over_next  = (rx_rise ? 1'b0 : overlong_q) || (32'(bits_sum) > FRAME_W);
        rx_eof     = !ctrl_rx_dv && rx_dv_q;
        frame_good = (rx_bits_q == 8'(FRAME_W)) && !overlong_q && (rx_crc_q == 16'h0000);
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_dv_q      <= 1'b0;
            rx_sh_q      <= '0;
            rx_crc_q     <= '0;
            rx_bits_q    <= '0;
            overlong_q   <= 1'b0;
            rx_valid_q   <= 1'b0;
            rx_err_q     <= 1'b0;
            rx_good_q    <= 1'b0;
            rx_payload_q <= '0;
            good_cnt_q   <= '0;
            err_cnt_q    <= '0;
        end else begin
            rx_dv_q    <= ctrl_rx_dv;
            rx_valid_q <= rx_eof && frame_good;
            rx_err_q   <= rx_eof && !frame_good;
            if (ctrl_rx_dv) begin
                rx_sh_q    <= {rx_sh_q[FRAME_W-LANE_W-1:0], ctrl_rx_data};
                rx_crc_q   <= crc_step(crc_seed, ctrl_rx_data);
                rx_bits_q  <= bits_next;
                overlong_q <= over_next;
            end
            // A frame verdict in the same cycle as an accepted tx_start takes precedence
            if (rx_eof && frame_good) begin
                rx_payload_q <= rx_sh_q[FRAME_W-1 -: PAYLOAD_W];
                rx_good_q    <= 1'b1;
                if (~&good_cnt_q) good_cnt_q <= good_cnt_q + CNT_W'(1);
            end else if (rx_eof) begin
                rx_good_q <= 1'b0;
                if (~&err_cnt_q) err_cnt_q <= err_cnt_q + CNT_W'(1);
            end else if (tx_accept) begin
                rx_good_q <= 1'b0;
            end
        end
    end

    assign rx_payload_o = rx_payload_q;
    assign rx_valid     = rx_valid_q;
    assign rx_err       = rx_err_q;
    assign rx_good      = rx_good_q;
    assign rx_good_cnt  = good_cnt_q;
    assign rx_err_cnt   = err_cnt_q;
    assign rx_bit_cnt_o = rx_bits_q;

endmodule

// File: tb/tb_ctrl_frame_transceiver.sv
// Directed bench for ctrl_frame_transceiver: known CRC vector, loopback, corrupted and
// mis-sized frames, back-to-back frames, busy/reset behaviour and counter saturation.
module tb_ctrl_frame_transceiver;
    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    localparam logic [127:0] PAY_A = 128'hA5B6C7D8E9FA0B1C2D3E4F5061728394;
    localparam logic [127:0] PAY_B = 128'h0123456789ABCDEF0F1E2D3C4B5A6978;
    localparam logic [127:0] PAY_C = 128'hFEDCBA98765432100011223344556677;

    // Main instance: defaults, rx either looped back from tx or driven directly
    logic         m_start;
    logic [127:0] m_payload;
    logic         m_busy, m_done, m_tx_clk, m_tx_en, m_rx_clk, m_rx_dv;
    logic [1:0]   m_tx_data, m_rx_data;
    logic [127:0] m_rx_payload;
    logic         m_rx_valid, m_rx_err, m_rx_good;
    logic [15:0]  m_good_cnt, m_err_cnt;
    logic [7:0]   m_bit_cnt;
    logic         lb, corrupt, drv_dv;
    logic [1:0]   drv_data;
    int           lb_beat = 0;

    always @(posedge sys_clk) lb_beat <= m_tx_en ? lb_beat + 1 : 0;
    assign m_rx_dv   = lb ? m_tx_en : drv_dv;
    assign m_rx_data = lb ? (m_tx_data ^ ((corrupt && lb_beat == 10) ? 2'b10 : 2'b00)) : drv_data;

    ctrl_frame_transceiver dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .tx_start(m_start), .tx_payload_i(m_payload),
        .tx_busy(m_busy), .tx_done(m_done), .ctrl_tx_clk(m_tx_clk), .ctrl_tx_en(m_tx_en),
        .ctrl_tx_data(m_tx_data), .ctrl_rx_clk(m_rx_clk), .ctrl_rx_dv(m_rx_dv),
        .ctrl_rx_data(m_rx_data), .rx_payload_o(m_rx_payload), .rx_valid(m_rx_valid),
        .rx_err(m_rx_err), .rx_good(m_rx_good), .rx_good_cnt(m_good_cnt),
        .rx_err_cnt(m_err_cnt), .rx_bit_cnt_o(m_bit_cnt)
    );

    // 72-bit payload instance for the "123456789" CRC vector
    logic         p_start;
    logic [71:0]  p_payload, p_rx_payload;
    logic         p_busy, p_done, p_tx_clk, p_tx_en, p_rx_clk;
    logic [1:0]   p_tx_data;
    logic         p_rx_valid, p_rx_err, p_rx_good;
    logic [15:0]  p_good_cnt, p_err_cnt;
    logic [7:0]   p_bit_cnt;

    ctrl_frame_transceiver #(.PAYLOAD_W(72)) dut72 (
        .sys_clk(sys_clk), .rst_n(rst_n), .tx_start(p_start), .tx_payload_i(p_payload),
        .tx_busy(p_busy), .tx_done(p_done), .ctrl_tx_clk(p_tx_clk), .ctrl_tx_en(p_tx_en),
        .ctrl_tx_data(p_tx_data), .ctrl_rx_clk(p_rx_clk), .ctrl_rx_dv(1'b0),
        .ctrl_rx_data(2'b00), .rx_payload_o(p_rx_payload), .rx_valid(p_rx_valid),
        .rx_err(p_rx_err), .rx_good(p_rx_good), .rx_good_cnt(p_good_cnt),
        .rx_err_cnt(p_err_cnt), .rx_bit_cnt_o(p_bit_cnt)
    );

    // 4-bit counter instance, permanently looped back
    logic         s_start;
    logic [127:0] s_payload, s_rx_payload;
    logic         s_busy, s_done, s_tx_clk, s_tx_en, s_rx_clk;
    logic [1:0]   s_tx_data;
    logic         s_rx_valid, s_rx_err, s_rx_good;
    logic [3:0]   s_good_cnt, s_err_cnt;
    logic [7:0]   s_bit_cnt;

    ctrl_frame_transceiver #(.CNT_W(4)) dutsat (
        .sys_clk(sys_clk), .rst_n(rst_n), .tx_start(s_start), .tx_payload_i(s_payload),
        .tx_busy(s_busy), .tx_done(s_done), .ctrl_tx_clk(s_tx_clk), .ctrl_tx_en(s_tx_en),
        .ctrl_tx_data(s_tx_data), .ctrl_rx_clk(s_rx_clk), .ctrl_rx_dv(s_tx_en),
        .ctrl_rx_data(s_tx_data), .rx_payload_o(s_rx_payload), .rx_valid(s_rx_valid),
        .rx_err(s_rx_err), .rx_good(s_rx_good), .rx_good_cnt(s_good_cnt),
        .rx_err_cnt(s_err_cnt), .rx_bit_cnt_o(s_bit_cnt)
    );

    int m_vseen = 0;
    int m_eseen = 0;
    always @(negedge sys_clk) begin
        if (m_rx_valid) m_vseen = m_vseen + 1;
        if (m_rx_err)   m_eseen = m_eseen + 1;
    end

    function automatic logic [15:0] crc16(input logic [127:0] d);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 127; i >= 0; i--) begin
            if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    task automatic drive_frame(input logic [159:0] v, input int beats);
        for (int i = 0; i < beats; i++) begin
            @(negedge sys_clk);
            drv_dv   = 1'b1;
            drv_data = v[159 - 2*i -: 2];
        end
        @(negedge sys_clk);
        drv_dv   = 1'b0;
        drv_data = 2'b00;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m_start = 0; m_payload = '0; p_start = 0; p_payload = '0; s_start = 0; s_payload = PAY_C;
        lb = 0; corrupt = 0; drv_dv = 0; drv_data = 2'b00;
        repeat (3) @(negedge sys_clk);
        rst_n = 1'b1;
        @(negedge sys_clk);
        n_checks++;
        if ({m_busy, m_done, m_tx_en, m_tx_data} !== 5'b0)
            $display("FAIL reset_tx got %b want 00000", {m_busy, m_done, m_tx_en, m_tx_data});
        else n_pass++;
        n_checks++;
        if (m_rx_payload !== 128'h0) $display("FAIL reset_payload got %h want 0", m_rx_payload);
        else n_pass++;
        n_checks++;
        if ({m_rx_valid, m_rx_err, m_rx_good} !== 3'b0)
            $display("FAIL reset_rx_flags got %b want 000", {m_rx_valid, m_rx_err, m_rx_good});
        else n_pass++;
        n_checks++;
        if ({m_good_cnt, m_err_cnt, m_bit_cnt} !== 40'h0)
            $display("FAIL reset_counters got %h/%h/%h want 0", m_good_cnt, m_err_cnt, m_bit_cnt);
        else n_pass++;
    endtask

    task automatic test_crc_vector();
        int en_cnt = 0, first_en = -1, last_en = -1, done_cnt = 0, done_cyc = -1, idle_cyc = -1;
        logic [87:0] frame = '0;
        @(negedge sys_clk);
        p_payload = 72'h313233343536373839;
        p_start   = 1'b1;
        @(negedge sys_clk);
        p_start   = 1'b0;
        for (int c = 0; c < 120; c++) begin
            if (p_tx_en) begin
                if (first_en < 0) first_en = c;
                last_en = c;
                en_cnt++;
                frame = {frame[85:0], p_tx_data};
            end
            if (p_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (done_cyc >= 0 && idle_cyc < 0 && !p_busy) idle_cyc = c;
            @(negedge sys_clk);
        end
        n_checks++;
        if (first_en !== 0 || last_en !== 43)
            $display("FAIL crc_en_window got %0d..%0d want 0..43", first_en, last_en);
        else n_pass++;
        n_checks++;
        if (en_cnt !== 44) $display("FAIL crc_en_cycles got %0d want 44", en_cnt);
        else n_pass++;
        n_checks++;
        if (frame[15:0] !== 16'h29B1) $display("FAIL crc_value got %h want 29b1", frame[15:0]);
        else n_pass++;
        n_checks++;
        if (frame[87:16] !== 72'h313233343536373839)
            $display("FAIL crc_payload_beats got %h want 313233343536373839", frame[87:16]);
        else n_pass++;
        n_checks++;
        if (done_cnt !== 1 || done_cyc !== 44)
            $display("FAIL crc_done got count %0d cycle %0d want 1 at 44", done_cnt, done_cyc);
        else n_pass++;
        n_checks++;
        if (idle_cyc - done_cyc !== 2)
            $display("FAIL crc_gap got %0d want 2", idle_cyc - done_cyc);
        else n_pass++;
    endtask

    task automatic test_loopback();
        int v0 = m_vseen, e0 = m_eseen;
        lb = 1'b1; corrupt = 1'b0;
        @(negedge sys_clk);
        m_payload = PAY_A; m_start = 1'b1;
        @(negedge sys_clk);
        m_start = 1'b0;
        repeat (120) @(negedge sys_clk);
        n_checks++;
        if (m_vseen - v0 !== 1 || m_eseen - e0 !== 0)
            $display("FAIL lb_pulses got valid %0d err %0d want 1/0", m_vseen - v0, m_eseen - e0);
        else n_pass++;
        n_checks++;
        if (m_rx_payload !== PAY_A) $display("FAIL lb_payload got %h want %h", m_rx_payload, PAY_A);
        else n_pass++;
        n_checks++;
        if (m_rx_good !== 1'b1 || m_good_cnt !== 16'd1)
            $display("FAIL lb_good got %b cnt %0d want 1/1", m_rx_good, m_good_cnt);
        else n_pass++;
        n_checks++;
        if (m_bit_cnt !== 8'd144) $display("FAIL lb_bits got %0d want 144", m_bit_cnt);
        else n_pass++;
    endtask

    task automatic test_corrupt();
        int v0 = m_vseen, e0 = m_eseen;
        corrupt = 1'b1;
        @(negedge sys_clk);
        m_payload = PAY_A; m_start = 1'b1;
        @(negedge sys_clk);
        m_start = 1'b0;
        repeat (120) @(negedge sys_clk);
        corrupt = 1'b0;
        lb = 1'b0;
        n_checks++;
        if (m_eseen - e0 !== 1 || m_vseen - v0 !== 0)
            $display("FAIL bad_pulses got err %0d valid %0d want 1/0", m_eseen - e0, m_vseen - v0);
        else n_pass++;
        n_checks++;
        if (m_err_cnt !== 16'd1 || m_good_cnt !== 16'd1)
            $display("FAIL bad_counts got err %0d good %0d want 1/1", m_err_cnt, m_good_cnt);
        else n_pass++;
        n_checks++;
        if (m_rx_good !== 1'b0) $display("FAIL bad_good got %b want 0", m_rx_good);
        else n_pass++;
        n_checks++;
        if (m_rx_payload !== PAY_A) $display("FAIL bad_hold got %h want %h", m_rx_payload, PAY_A);
        else n_pass++;
    endtask

    task automatic test_length();
        int v0 = m_vseen, e0 = m_eseen;
        drive_frame({PAY_B, 32'hC0FFEE11}, 70);
        repeat (3) @(negedge sys_clk);
        n_checks++;
        if (m_eseen - e0 !== 1 || m_bit_cnt !== 8'd140 || m_err_cnt !== 16'd2)
            $display("FAIL short_frame got err %0d bits %0d cnt %0d want 1/140/2",
                     m_eseen - e0, m_bit_cnt, m_err_cnt);
        else n_pass++;
        // Correct CRC followed by one zero beat: the residue stays zero, only length can reject
        drive_frame({PAY_B, crc16(PAY_B), 16'h0000}, 73);
        repeat (3) @(negedge sys_clk);
        n_checks++;
        if (m_eseen - e0 !== 2 || m_vseen - v0 !== 0)
            $display("FAIL long_frame got err %0d valid %0d want 2/0", m_eseen - e0, m_vseen - v0);
        else n_pass++;
        n_checks++;
        if (m_bit_cnt !== 8'd146 || m_err_cnt !== 16'd3)
            $display("FAIL long_counts got bits %0d cnt %0d want 146/3", m_bit_cnt, m_err_cnt);
        else n_pass++;
        n_checks++;
        if (m_rx_payload !== PAY_A) $display("FAIL long_hold got %h want %h", m_rx_payload, PAY_A);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int v0 = m_vseen, e0 = m_eseen;
        drive_frame({PAY_B, crc16(PAY_B), 16'h0000}, 72);
        drive_frame({PAY_C, crc16(PAY_C), 16'h0000}, 72);
        repeat (3) @(negedge sys_clk);
        n_checks++;
        if (m_vseen - v0 !== 2 || m_eseen - e0 !== 0)
            $display("FAIL b2b_pulses got valid %0d err %0d want 2/0", m_vseen - v0, m_eseen - e0);
        else n_pass++;
        n_checks++;
        if (m_good_cnt !== 16'd3 || m_rx_good !== 1'b1)
            $display("FAIL b2b_good got cnt %0d good %b want 3/1", m_good_cnt, m_rx_good);
        else n_pass++;
        n_checks++;
        if (m_rx_payload !== PAY_C) $display("FAIL b2b_payload got %h want %h", m_rx_payload, PAY_C);
        else n_pass++;
    endtask

    task automatic test_busy_ignore();
        int en_cnt = 0, done_cnt = 0;
        logic good_after = 1'b1;
        @(negedge sys_clk);
        m_payload = PAY_B; m_start = 1'b1;
        @(negedge sys_clk);
        m_start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (c == 0) good_after = m_rx_good;
            if (m_tx_en) en_cnt++;
            if (m_done) done_cnt++;
            m_start = (c == 10 || c == 73);
            @(negedge sys_clk);
        end
        m_start = 1'b0;
        n_checks++;
        if (good_after !== 1'b0) $display("FAIL start_clears_good got %b want 0", good_after);
        else n_pass++;
        n_checks++;
        if (en_cnt !== 72 || done_cnt !== 1)
            $display("FAIL busy_ignore got en %0d done %0d want 72/1", en_cnt, done_cnt);
        else n_pass++;
        n_checks++;
        if (m_good_cnt !== 16'd3 || m_rx_payload !== PAY_C)
            $display("FAIL start_keeps_rx got cnt %0d payload %h want 3/%h",
                     m_good_cnt, m_rx_payload, PAY_C);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int en_cnt = 0, done_cnt = 0;
        @(negedge sys_clk);
        m_payload = PAY_A; m_start = 1'b1;
        @(negedge sys_clk);
        m_start = 1'b0;
        repeat (20) @(negedge sys_clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (m_tx_en !== 1'b0 || m_busy !== 1'b0)
            $display("FAIL reset_abort got en %b busy %b want 0/0", m_tx_en, m_busy);
        else n_pass++;
        @(negedge sys_clk);
        rst_n = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (m_tx_en) en_cnt++;
            if (m_done) done_cnt++;
            @(negedge sys_clk);
        end
        n_checks++;
        if (en_cnt !== 0 || done_cnt !== 0)
            $display("FAIL reset_quiet got en %0d done %0d want 0/0", en_cnt, done_cnt);
        else n_pass++;
        n_checks++;
        if (m_good_cnt !== 16'd0 || m_rx_payload !== 128'h0)
            $display("FAIL reset_rx_clear got cnt %0d payload %h want 0/0", m_good_cnt, m_rx_payload);
        else n_pass++;
    endtask

    task automatic test_saturation();
        for (int f = 0; f < 17; f++) begin
            int t = 0;
            @(negedge sys_clk);
            s_start = 1'b1;
            @(negedge sys_clk);
            s_start = 1'b0;
            while (s_busy && t < 400) begin
                @(negedge sys_clk);
                t++;
            end
            n_checks++;
            if (s_busy) $display("FAIL sat_timeout frame %0d busy %b want 0", f, s_busy);
            else n_pass++;
            if (f == 13) begin
                n_checks++;
                if (s_good_cnt !== 4'hE) $display("FAIL sat_count14 got %h want e", s_good_cnt);
                else n_pass++;
            end
        end
        repeat (3) @(negedge sys_clk);
        n_checks++;
        if (s_good_cnt !== 4'hF) $display("FAIL sat_hold got %h want f", s_good_cnt);
        else n_pass++;
        n_checks++;
        if (s_err_cnt !== 4'h0 || s_rx_payload !== PAY_C)
            $display("FAIL sat_clean got err %h payload %h want 0/%h", s_err_cnt, s_rx_payload, PAY_C);
        else n_pass++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_crc_vector();
        test_loopback();
        test_corrupt();
        test_length();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
